// File: rtl/leitor_resultado_matriz.sv
// -----------------------------------------------------------------------------
// leitor_resultado_matriz
//
// Result-side streamer for the matrix coprocessor. A readout request waits
// LATENCIA clock edges for the operation unit's registered 5x5 result. It then
// snapshots all 200 bits. Finally it streams the active n x n window in
// row-major order, one signed 8-bit element per valid/ready transfer.
//
// Parameters:
//   LATENCIA   edges from the start-sampling edge to the capture edge (1..15)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      readout request, only honoured while idle
//   tamanho    matrix order n, sampled with start (values outside 2..5 -> 5)
//   resultado  flattened 5x5 signed matrix, element k=5i+j at bits 8k..8k+7
//              (bit 8k is the MSB)
//   dado       element currently offered
//   valido     dado/linha/coluna/ultimo are valid
//   pronto     consumer ready; a transfer happens on valido && pronto
//   linha      row index of dado
//   coluna     column index of dado
//   ultimo     marks element (n-1,n-1)
//   ocupado    high from start acceptance until the final transfer edge
//   concluido  one-cycle pulse after the final transfer
// -----------------------------------------------------------------------------
module leitor_resultado_matriz #(
    parameter int LATENCIA = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        tamanho,
    input  logic [0:199]      resultado,
    output logic signed [7:0] dado,
    output logic              valido,
    input  logic              pronto,
    output logic [2:0]        linha,
    output logic [2:0]        coluna,
    output logic              ultimo,
    output logic              ocupado,
    output logic              concluido
);

    typedef enum logic [1:0] {
        OCIOSO,
        ESPERA,
        ENVIA
    } estado_t;

    estado_t            estado, estado_prox;
    logic [3:0]         cont, cont_prox;
    logic [2:0]         n, n_prox;
    logic [0:199]       snap, snap_prox;

    logic signed [7:0]  dado_prox;
    logic               valido_prox;
    logic [2:0]         linha_prox, coluna_prox;
    logic               ultimo_prox;
    logic               ocupado_prox;
    logic               concluido_prox;

    // Position that follows (linha, coluna) inside the n x n window.
    logic [2:0]         lin_seg, col_seg;

    // Orders outside 2..5 collapse to the full 5x5 matrix.
    function automatic logic [2:0] ordem_efetiva(input logic [2:0] t);
        return (t >= 3'd2 && t <= 3'd5) ? t : 3'd5;
    endfunction

    // Element (i,j) of a flattened matrix; the ascending bit range makes
    // bit 8k the MSB of element k, so the slice is already in signed order.
    function automatic logic signed [7:0] elemento(input logic [0:199] m,
                                                    input logic [2:0]   i,
                                                    input logic [2:0]   j);
        int k;
        k = 5 * int'(i) + int'(j);
        return m[8*k +: 8];
    endfunction

    always_comb begin
        lin_seg = linha;
        col_seg = coluna + 3'd1;
        if (coluna == n - 3'd1) begin
            col_seg = 3'd0;
            lin_seg = linha + 3'd1;
        end
    end

    always_comb begin
        estado_prox    = estado;
        cont_prox      = cont;
        n_prox         = n;
        snap_prox      = snap;
        dado_prox      = dado;
        valido_prox    = valido;
        linha_prox     = linha;
        coluna_prox    = coluna;
        ultimo_prox    = ultimo;
        ocupado_prox   = ocupado;
        concluido_prox = 1'b0;

        case (estado)
            OCIOSO: begin
                if (start) begin
                    n_prox       = ordem_efetiva(tamanho);
                    // The counter reaches zero on the edge before capture,
                    // so LATENCIA=1 captures on the very next edge.
                    cont_prox    = 4'(LATENCIA - 1);
                    ocupado_prox = 1'b1;
                    estado_prox  = ESPERA;
                end
            end

            ESPERA: begin
                if (cont == 4'd0) begin
                    snap_prox   = resultado;
                    dado_prox   = elemento(resultado, 3'd0, 3'd0);
                    valido_prox = 1'b1;
                    linha_prox  = 3'd0;
                    coluna_prox = 3'd0;
                    // n is at least 2, so (0,0) is never the last element.
                    ultimo_prox = 1'b0;
                    estado_prox = ENVIA;
                end else begin
                    cont_prox = cont - 4'd1;
                end
            end

            ENVIA: begin
                if (pronto) begin
                    if (ultimo) begin
                        valido_prox    = 1'b0;
                        ultimo_prox    = 1'b0;
                        ocupado_prox   = 1'b0;
                        concluido_prox = 1'b1;
                        estado_prox    = OCIOSO;
                    end else begin
                        linha_prox  = lin_seg;
                        coluna_prox = col_seg;
                        dado_prox   = elemento(snap, lin_seg, col_seg);
                        ultimo_prox = (lin_seg == n - 3'd1) && (col_seg == n - 3'd1);
                    end
                end
            end

            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado    <= OCIOSO;
            cont      <= 4'd0;
            n         <= 3'd0;
            snap      <= '0;
            dado      <= '0;
            valido    <= 1'b0;
            linha     <= 3'd0;
            coluna    <= 3'd0;
            ultimo    <= 1'b0;
            ocupado   <= 1'b0;
            concluido <= 1'b0;
        end else begin
            estado    <= estado_prox;
            cont      <= cont_prox;
            n         <= n_prox;
            snap      <= snap_prox;
            dado      <= dado_prox;
            valido    <= valido_prox;
            linha     <= linha_prox;
            coluna    <= coluna_prox;
            ultimo    <= ultimo_prox;
            ocupado   <= ocupado_prox;
            concluido <= concluido_prox;
        end
    end

endmodule
